// File: rtl/lcd_bus_arbiter_if.sv
// Byte-level LCD bus bundle shared by requesters, arbiter and LCD controller.
// Requester side: iREQ/iLOCK/iDATA/iRS/iSTART in, oGNT/oDONE back; LCD side: oLCD_* out, iLCD_DONE in.
interface lcd_bus_arbiter_if #(
  parameter int N = 3
);
  logic [N-1:0]   iREQ;
  logic [N-1:0]   iLOCK;
  logic [8*N-1:0] iDATA;
  logic [N-1:0]   iRS;
  logic [N-1:0]   iSTART;
  logic [N-1:0]   oGNT;
  logic [N-1:0]   oDONE;
  logic           oBUSY;
  logic [1:0]     oOWNER;
  logic [7:0]     oLCD_DATA;
  logic           oLCD_RS;
  logic           oLCD_START;
  logic           iLCD_DONE;

  modport master (
    output iREQ, iLOCK, iDATA, iRS, iSTART, iLCD_DONE,
    input  oGNT, oDONE, oBUSY, oOWNER,
    input  oLCD_DATA, oLCD_RS, oLCD_START
  );

  modport slave (
    input  iREQ, iLOCK, iDATA, iRS, iSTART, iLCD_DONE,
    output oGNT, oDONE, oBUSY, oOWNER,
    output oLCD_DATA, oLCD_RS, oLCD_START
  );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter sharing one LCD byte port among N requesters, with lock and stall timeout.
// Ports: iCLK, iRST_N (async active-low), bus (slave modport of lcd_bus_arbiter_if).
module lcd_bus_arbiter #(
  parameter int N       = 3,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  lcd_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    XFER,
    WREL
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  done_q, done_d;
  logic [1:0]    own_q, own_d;
  logic [7:0]    dat_q, dat_d;
  logic          rs_q, rs_d;
  logic          st_q, st_d;
  logic [TW-1:0] cnt_q, cnt_d;

  logic [1:0]    pick;
  logic [1:0]    idx;
  logic          pick_vld;
  logic          own_req;
  logic          own_lock;
  logic          own_start;

  assign own_req   = bus.iREQ[own_q];
  assign own_lock  = bus.iLOCK[own_q];
  assign own_start = bus.iSTART[own_q];

  // Scan from farthest to nearest so the requester right after
  // the previous owner wins; the previous owner ranks last.
  always_comb begin
    pick_vld = 1'b0;
    pick     = own_q;
    idx      = own_q;
    for (int i = N; i >= 1; i--) begin
      idx = 2'((32'(own_q) + i) % N);
      if (bus.iREQ[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      own_q   <= 2'(N - 1);
      dat_q   <= '0;
      rs_q    <= 1'b0;
      st_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      own_q   <= own_d;
      dat_q   <= dat_d;
      rs_q    <= rs_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    own_d   = own_q;
    dat_d   = dat_q;
    rs_d    = rs_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_vld) begin
          gnt_d[pick] = 1'b1;
          own_d       = pick;
          cnt_d       = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (!own_req) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else if (own_start) begin
          dat_d   = bus.iDATA[{own_q, 3'b000} +: 8];
          rs_d    = bus.iRS[own_q];
          st_d    = 1'b1;
          state_d = XFER;
        end else begin
          if (cnt_q != TW'(TIMEOUT)) begin
            cnt_d = cnt_q + 1'b1;
          end
          // Release on the cycle the count reaches TIMEOUT.
          if (cnt_q >= TW'(TIMEOUT - 1)) begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      XFER: begin
        if (bus.iLCD_DONE) begin
          st_d    = 1'b0;
          done_d  = gnt_q;
          state_d = WREL;
        end
      end
      WREL: begin
        if (!own_start) begin
          if (own_req && own_lock) begin
            cnt_d   = '0;
            state_d = GRANT;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.oGNT       = gnt_q;
    bus.oDONE      = done_q;
    bus.oBUSY      = (state_q != IDLE);
    bus.oOWNER     = own_q;
    bus.oLCD_DATA  = dat_q;
    bus.oLCD_RS    = rs_q;
    bus.oLCD_START = st_q;
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: requester agents, LCD responder, cycle model.
// Directed scenarios with literal checks plus per-cycle output comparison.
module tb_lcd_bus_arbiter;
  localparam int N       = 3;
  localparam int TIMEOUT = 1023;
  localparam int LAT     = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  lcd_bus_arbiter_if #(.N(N)) bus ();

  lcd_bus_arbiter #(
    .N      (N),
    .TIMEOUT(TIMEOUT),
    .TW     (10)
  ) dut (
    .iCLK  (clk),
    .iRST_N(rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // requester byte scripts: bench writes mem/n, agents advance rd
  logic [8:0]  mem [N][64];
  int          n   [N] = '{default: 0};
  int          rd  [N];
  bit          started [N];
  bit          lockm   [N] = '{default: 1'b0};
  bit          stall   [N] = '{default: 1'b0};
  bit          drop_req[N] = '{default: 1'b0};
  bit          lcd_hold = 1'b0;
  int          lat;
  logic [10:0] log_q[$];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.iREQ   = '0;
      bus.iLOCK  = '0;
      bus.iSTART = '0;
      bus.iRS    = '0;
      bus.iDATA  = '0;
      for (int k = 0; k < N; k++) begin
        rd[k]      = n[k];
        started[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (started[k]) begin
          if (drop_req[k] && bus.oLCD_START) bus.iREQ[k] = 1'b0;
          if (bus.oDONE[k]) begin
            started[k]    = 1'b0;
            bus.iSTART[k] = 1'b0;
            rd[k]         = rd[k] + 1;
            bus.iREQ[k]   = (rd[k] < n[k]);
            bus.iLOCK[k]  = lockm[k] && (rd[k] < n[k]);
          end
        end else if (rd[k] < n[k]) begin
          bus.iREQ[k]  = 1'b1;
          bus.iLOCK[k] = lockm[k];
          if (bus.oGNT[k]) begin
            started[k]          = 1'b1;
            bus.iSTART[k]       = 1'b1;
            bus.iDATA[k*8 +: 8] = mem[k][rd[k]][7:0];
            bus.iRS[k]          = mem[k][rd[k]][8];
          end
        end else begin
          bus.iREQ[k]  = stall[k];
          bus.iLOCK[k] = 1'b0;
        end
      end
    end
  end

  // LCD controller stand-in: done pulse LAT+1 cycles after start seen
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.iLCD_DONE = 1'b0;
      lat           = LAT;
    end else if (bus.iLCD_DONE) begin
      bus.iLCD_DONE = 1'b0;
    end else if (bus.oLCD_START && !lcd_hold) begin
      if (lat == 0) begin
        bus.iLCD_DONE = 1'b1;
        log_q.push_back({bus.oOWNER, bus.oLCD_RS, bus.oLCD_DATA});
        lat = LAT;
      end else begin
        lat = lat - 1;
      end
    end
  end

  // model: owner index or -1, byte in flight, waiting for start drop
  int         m_own, m_gnt, m_done, m_idle, m_c;
  bit         m_xfer, m_wrel;
  logic [7:0] m_dat;
  logic       m_rs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own = N - 1; m_gnt = -1; m_done = -1; m_idle = 0;
      m_xfer = 0; m_wrel = 0; m_dat = '0; m_rs = 1'b0;
    end else begin
      m_done = -1;
      if (m_gnt < 0) begin
        m_c = -1;
        for (int i = 1; i <= N; i++)
          if (m_c < 0 && bus.iREQ[(m_own + i) % N] === 1'b1)
            m_c = (m_own + i) % N;
        if (m_c >= 0) begin
          m_gnt = m_c; m_own = m_c; m_idle = 0;
        end
      end else if (m_xfer) begin
        if (bus.iLCD_DONE) begin
          m_xfer = 0; m_wrel = 1; m_done = m_gnt;
        end
      end else if (m_wrel) begin
        if (!bus.iSTART[m_gnt]) begin
          m_wrel = 0;
          if (bus.iREQ[m_gnt] && bus.iLOCK[m_gnt]) m_idle = 0;
          else m_gnt = -1;
        end
      end else if (!bus.iREQ[m_gnt]) begin
        m_gnt = -1;
      end else if (bus.iSTART[m_gnt]) begin
        m_dat = bus.iDATA[m_gnt*8 +: 8];
        m_rs = bus.iRS[m_gnt];
        m_xfer = 1;
      end else begin
        m_idle = m_idle + 1;
        if (m_idle >= TIMEOUT) m_gnt = -1;
      end
    end
  end

  logic [N-1:0]    eg, ed;
  logic [2*N+12:0] exp_v, act_v;

  always @(negedge clk) begin
    if (rst_n) begin
      eg = '0;
      ed = '0;
      if (m_gnt >= 0) eg[m_gnt] = 1'b1;
      if (m_done >= 0) ed[m_done] = 1'b1;
      exp_v = {eg, ed, (m_gnt >= 0), 2'(m_own), m_dat, m_rs, m_xfer};
      act_v = {bus.oGNT, bus.oDONE, bus.oBUSY, bus.oOWNER,
               bus.oLCD_DATA, bus.oLCD_RS, bus.oLCD_START};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t got %h expected %h", $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic rs, input logic [7:0] d);
    mem[k][n[k]] = {rs, d};
    n[k] = n[k] + 1;
  endtask

  function automatic bit agents_idle();
    for (int k = 0; k < N; k++)
      if (rd[k] < n[k] || started[k] || stall[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_gnt(input int k, input string nm);
    int c;
    c = 0;
    @(negedge clk);
    while (!bus.oGNT[k] && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_grant_seen"}, 32'(bus.oGNT[k]), 32'd1);
  endtask

  task automatic wait_any_gnt(input string nm);
    int c;
    c = 0;
    @(negedge clk);
    while (bus.oGNT == '0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_any_grant"}, 32'(bus.oGNT != '0), 32'd1);
  endtask

  task automatic wait_start(input string nm);
    int c;
    c = 0;
    @(negedge clk);
    while (!bus.oLCD_START && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_lcd_start_seen"}, 32'(bus.oLCD_START), 32'd1);
  endtask

  task automatic wait_quiet(input string nm, output int dn);
    int c;
    c = 0;
    dn = 0;
    @(negedge clk);
    while (!(agents_idle() && !bus.oBUSY) && c < 3000) begin
      dn = dn + $countones(bus.oDONE);
      @(negedge clk);
      c++;
    end
    chk({nm, "_quiet"}, 32'(agents_idle() && !bus.oBUSY), 32'd1);
  endtask

  int base, dn, cnt;
  int ord[6] = '{1, 2, 0, 1, 2, 0};
  int bad;

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_outputs",
        32'({bus.oGNT, bus.oDONE, bus.oBUSY, bus.oOWNER,
             bus.oLCD_DATA, bus.oLCD_RS, bus.oLCD_START}),
        32'({3'b000, 3'b000, 1'b0, 2'd2, 8'h00, 1'b0, 1'b0}));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single byte, no lock
    @(posedge clk); #1;
    base = log_q.size();
    push(0, 1'b1, 8'h41);
    wait_gnt(0, "single");
    chk("single_gnt", 32'(bus.oGNT), 32'b001);
    wait_start("single");
    chk("single_data", 32'(bus.oLCD_DATA), 32'h41);
    chk("single_rs", 32'(bus.oLCD_RS), 32'd1);
    wait_quiet("single", dn);
    chk("single_done_pulses", 32'(dn), 32'd1);
    chk("single_log", 32'(log_q[base]), 32'({2'd0, 1'b1, 8'h41}));

    // round robin with all three requesting
    @(posedge clk); #1;
    base = log_q.size();
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < N; k++)
        push(k, k[0], 8'(16 * k + j));
    wait_quiet("rr", dn);
    chk("rr_done_pulses", 32'(dn), 32'd6);
    chk("rr_log_size", 32'(log_q.size() - base), 32'd6);
    bad = 0;
    for (int i = 0; i < 6; i++)
      if (log_q[base + i] !== {2'(ord[i]), 1'(ord[i] % 2), 8'(16 * ord[i] + i / 3)})
        bad++;
    chk("rr_order", 32'(bad), 32'd0);

    // lock burst of 33 bytes from requester 1
    @(posedge clk); #1;
    base = log_q.size();
    lockm[1] = 1'b1;
    for (int i = 0; i < 33; i++) push(1, 1'b1, 8'(8'h80 + i));
    wait_gnt(1, "lock");
    @(posedge clk); #1;
    push(0, 1'b0, 8'hA0);
    push(0, 1'b0, 8'hA1);
    wait_quiet("lock", dn);
    lockm[1] = 1'b0;
    chk("lock_log_size", 32'(log_q.size() - base), 32'd35);
    bad = 0;
    for (int i = 0; i < 33; i++)
      if (log_q[base + i] !== {2'd1, 1'b1, 8'(8'h80 + i)}) bad++;
    chk("lock_burst_order", 32'(bad), 32'd0);
    chk("lock_after_0a", 32'(log_q[base + 33]), 32'({2'd0, 1'b0, 8'hA0}));
    chk("lock_after_0b", 32'(log_q[base + 34]), 32'({2'd0, 1'b0, 8'hA1}));

    // stalled owner 2 times out, pending requester 0 next
    @(posedge clk); #1;
    stall[2] = 1'b1;
    push(0, 1'b1, 8'h33);
    wait_gnt(2, "timeout");
    cnt = 0;
    while (bus.oGNT[2] && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    chk("timeout_len", 32'(cnt), 32'(TIMEOUT));
    chk("timeout_released", 32'(bus.oGNT), 32'b000);
    @(negedge clk);
    chk("timeout_next_gnt", 32'(bus.oGNT), 32'b001);
    stall[2] = 1'b0;
    wait_quiet("timeout", dn);
    chk("timeout_done_pulses", 32'(dn), 32'd1);

    // owner drops request mid-transfer
    @(posedge clk); #1;
    base = log_q.size();
    lcd_hold = 1'b1;
    drop_req[0] = 1'b1;
    push(0, 1'b0, 8'h55);
    wait_start("abort");
    repeat (3) @(negedge clk);
    chk("abort_req_dropped", 32'(bus.iREQ[0]), 32'd0);
    chk("abort_start_held", 32'(bus.oLCD_START), 32'd1);
    chk("abort_gnt_held", 32'(bus.oGNT), 32'b001);
    chk("abort_data_held", 32'(bus.oLCD_DATA), 32'h55);
    lcd_hold = 1'b0;
    wait_quiet("abort", dn);
    drop_req[0] = 1'b0;
    chk("abort_done_pulses", 32'(dn), 32'd1);
    chk("abort_log", 32'(log_q[base]), 32'({2'd0, 1'b0, 8'h55}));

    // async reset during a transfer
    @(posedge clk); #1;
    lcd_hold = 1'b1;
    push(0, 1'b1, 8'h77);
    wait_start("rst");
    #2 rst_n = 1'b0;
    #1;
    chk("rst_lcd_start", 32'(bus.oLCD_START), 32'd0);
    chk("rst_gnt", 32'(bus.oGNT), 32'b000);
    chk("rst_busy", 32'(bus.oBUSY), 32'd0);
    chk("rst_owner", 32'(bus.oOWNER), 32'd2);
    @(negedge clk);
    lcd_hold = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = log_q.size();
    push(0, 1'b0, 8'hC0);
    push(1, 1'b0, 8'hC1);
    wait_any_gnt("post_rst");
    chk("post_rst_gnt", 32'(bus.oGNT), 32'b001);
    wait_quiet("post_rst", dn);
    chk("post_rst_first", 32'(log_q[base]), 32'({2'd0, 1'b0, 8'hC0}));
    chk("post_rst_second", 32'(log_q[base + 1]), 32'({2'd1, 1'b0, 8'hC1}));

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
